// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux select sequencer.
// MUX_SEQ_MSB_FIRST_EN reverses the scan order (3,2,1,0).
package mux_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int HOLD_W = 4;

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam logic [1:0] SEL_FIRST = 2'd3;
  localparam logic [1:0] SEL_LAST  = 2'd0;
`else
  localparam logic [1:0] SEL_FIRST = 2'd0;
  localparam logic [1:0] SEL_LAST  = 2'd3;
`endif

  // Wraps from the final index back to the first one.
  function automatic logic [1:0] sel_next(
    input logic [1:0] sel
  );
`ifdef MUX_SEQ_MSB_FIRST_EN
    return sel - 2'd1;
`else
    return sel + 2'd1;
`endif
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Word intake and select/step handshake between the sequencer,
// its producer and the downstream mux consumer.
interface mux_sel_sequencer_if;

  logic [3:0] data_in;
  logic       data_valid_in;
  logic       data_ready_out;
  logic       step_ready_in;
  logic [3:0] d_out;
  logic [1:0] sel_out;
  logic       sel_valid_out;
  logic       last_out;
  logic       busy_out;

  modport master (
    output data_in,
    output data_valid_in,
    output step_ready_in,
    input  data_ready_out,
    input  d_out,
    input  sel_out,
    input  sel_valid_out,
    input  last_out,
    input  busy_out
  );

  modport slave (
    input  data_in,
    input  data_valid_in,
    input  step_ready_in,
    output data_ready_out,
    output d_out,
    output sel_out,
    output sel_valid_out,
    output last_out,
    output busy_out
  );

endinterface

// File: rtl/mux_seq_hold_cnt.sv
// Per-index hold counter: counts accepted cycles and flags
// the cycle that completes a step.
module mux_seq_hold_cnt
  import mux_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [HOLD_W-1:0] TC_VAL =
    HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt_q;

  assign tc = (cnt_q == TC_VAL);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Holds a 4-bit word and walks the mux select through every index.
// Scan order is set by MUX_SEQ_MSB_FIRST_EN (see mux_seq_pkg).
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  mux_sel_sequencer_if.slave   bus
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] d_q;
  logic [1:0] sel_q;
  logic       hold_tc;
  logic       in_scan;
  logic       step_en;
  logic       step_done;
  logic       final_done;
  logic       ready;
  logic       load;

  assign in_scan    = (state_q == SCAN);
  assign step_en    = in_scan & bus.step_ready_in;
  assign step_done  = step_en & hold_tc;
  assign final_done = step_done & (sel_q == SEL_LAST);
  assign load       = bus.data_valid_in & ready;

  mux_seq_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_cnt (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .en      (step_en),
    .clr     (load),
    .tc      (hold_tc)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (load) state_d = SCAN;
      end
      (state_q == SCAN): begin
        if (final_done && !bus.data_valid_in)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready opens in IDLE and on the cycle the last step completes.
  always_comb begin
    ready              = rst_n_in & (~in_scan | final_done);
    bus.data_ready_out = ready;
    bus.sel_valid_out  = in_scan;
    bus.busy_out       = in_scan;
    bus.last_out       = in_scan & (sel_q == SEL_LAST);
    bus.d_out          = d_q;
    bus.sel_out        = sel_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      d_q   <= '0;
      sel_q <= SEL_FIRST;
    end else if (load) begin
      d_q   <= bus.data_in;
      sel_q <= SEL_FIRST;
    end else if (step_done) begin
      sel_q <= sel_next(sel_q);
    end
  end

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Upstream stage for the 4-to-1 case multiplexer: accepts a 4-bit word over a valid/ready handshake, holds it on `d_out`, and steps `sel_out` through all four channel indices, holding each index for a programmable number of accepted cycles. The downstream mux then produces one channel bit per step, turning the block plus mux into a flow-controlled parallel-to-serial path. Back-to-back words stream with no bubble cycles.

## Interface
- `HOLD_CYCLES`, default 1, accepted cycles each `sel_out` value is held (legal 1..16)
- `clk_in`  input  1  single clock, rising edge
- `rst_n_in`  input  1  reset; asynchronous, active-low
- `data_in`  input  4  word to scan
- `data_valid_in`  input  1  `data_in` is valid
- `data_ready_out`  output  1  block can accept a word this cycle
- `step_ready_in`  input  1  downstream consumed the current mux output bit this cycle
- `d_out`  output  4  held word, drives mux `d_in`
- `sel_out`  output  2  channel index, drives mux `sel_in`
- `sel_valid_out`  output  1  `d_out`/`sel_out` (and therefore the mux output) are valid
- `last_out`  output  1  current index is the final index of the word
- `busy_out`  output  1  word in progress (state SCAN)

## Operation
- States: IDLE, SCAN.
- Reset (async assert, any state, including mid-word): state IDLE, `d_out`=0, `sel_out`=first index, hold count 0, `sel_valid_out`=0, `last_out`=0, `busy_out`=0; held word discarded. `data_ready_out` is 0 while `rst_n_in` is low.
- IDLE: `data_ready_out`=1. Accept (valid & ready) loads `d_out`, sets `sel_out` to first index, hold count 0, goes to SCAN.
- SCAN: `sel_valid_out`=1, `busy_out`=1. Each cycle with `step_ready_in`=1 is an accepted cycle: hold count increments; when hold count = `HOLD_CYCLES`-1 the step completes, hold count returns to 0, `sel_out` advances by one index. `step_ready_in`=0 freezes all state (backpressure, no timeout).
- `last_out`=1 whenever in SCAN and `sel_out` is the final index.
- Final step completion: `data_ready_out`=1 that cycle (combinational from `step_ready_in`, `last_out`, hold count). If `data_valid_in`=1 the next word loads and SCAN continues at first index; otherwise return to IDLE.
- `data_ready_out`=0 in SCAN at all other times; `data_in` ignored then.
- Hold counter width 4 bits; `HOLD_CYCLES`=1 means every accepted cycle completes a step.

## Timing
- Accept on edge N: `sel_valid_out`=1, `sel_out`=first index from after edge N.
- With `step_ready_in` held high: word occupies 4×`HOLD_CYCLES` cycles; back-to-back throughput 1 word per 4×`HOLD_CYCLES` cycles, no gap.
- Mux output valid in the same cycle as `sel_valid_out` (mux is combinational).
- All outputs registered except `data_ready_out`.

## Configuration
- `MUX_SEQ_MSB_FIRST_EN` defined: scan order 3,2,1,0; first index 3, final index 0.
- Undefined: scan order 0,1,2,3; first index 0, final index 3. Reset value of `sel_out` follows the first index.

## Structure
- Package `mux_seq_pkg`: state enum (IDLE, SCAN), `SEL_FIRST`/`SEL_LAST` constants selected by the macro, hold-count width constant.
- One sub-module: `mux_seq_hold_cnt` (hold counter with enable, clear, and terminal-count flag).

## Test plan
- Reset then `data_in`=4'b1010 valid, `step_ready_in`=1, HOLD=1 -> `sel_out` 0,1,2,3 on 4 consecutive cycles, mux output 0,1,0,1, `last_out` only on index 3, then IDLE.
- Two words 4'hC, 4'h3 back-to-back -> 8 contiguous `sel_valid_out` cycles, `data_ready_out` pulses only on the final-step cycle, mux stream 0,0,1,1,1,1,0,0.
- HOLD=3, `step_ready_in` low for 2 cycles during index 1 -> index 1 visible 5 cycles, word completes in 14 cycles.
- Assert `rst_n_in` low mid-word at index 2 -> all outputs 0 / first index immediately; after release, new word starts at first index.
- `MUX_SEQ_MSB_FIRST_EN` defined, `data_in`=4'b0001 -> `sel_out` 3,2,1,0, mux output 0,0,0,1, `last_out` at index 0.
- `data_valid_in` pulsed while busy (not final step) -> not accepted, `d_out` unchanged.
